// File: rtl/spi_target_regs.sv
// SPI mode-0 target with a small byte register file, oversampled in the clk domain.
// Byte 0 of a transaction is a command {rd, ..., addr}; following bytes stream data with auto-increment.
module spi_target_regs #(
  parameter int unsigned ADDR_W   = 3,
  parameter logic [7:0]  ID_VALUE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [7:0]        ctrl_out,
  input  logic [7:0]        status_in,
  output logic              wr_stb,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;

  typedef enum logic [1:0] {StIdle, StCmd, StWdata, StRdata} state_e;

  state_e              state_q, state_d;
  logic [2:0]          sclk_q, cs_q;
  logic [1:0]          mosi_q;
  logic [1:0]          fill_q;
  logic                armed_q, armed_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          rx_sr_q, rx_sr_d;
  logic [7:0]          tx_sr_q, tx_sr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                miso_q, miso_d;
  logic                wr_stb_q, wr_stb_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]          wr_data_q, wr_data_d;
  logic [7:0]          regs_q [NumRegs];
  logic [7:0]          regs_d [NumRegs];

  logic                sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [7:0]          rx_byte;
  logic [ADDR_W-1:0]   rd_addr;
  logic [7:0]          rd_val;

  // Stages [1:0] synchronise, stage [2] is the previous synchronised value for edge detection.
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];

  always_comb begin
    rx_byte = {rx_sr_q[6:0], mosi_q[1]};
    // The command byte supplies the first read address before addr_q holds it.
    rd_addr = (state_q == StCmd) ? rx_byte[ADDR_W-1:0] : addr_q;
    if (rd_addr == '0) begin
      rd_val = ID_VALUE;
    end else if (rd_addr == ADDR_W'(1)) begin
      rd_val = status_in;
    end else begin
      rd_val = regs_q[rd_addr];
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_sr_d   = rx_sr_q;
    tx_sr_d   = tx_sr_q;
    addr_d    = addr_q;
    miso_d    = miso_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    regs_d    = regs_q;
    // The sync flops reset to cs_n=1, so only arm once they hold a real pin sample.
    armed_d   = armed_q | (fill_q[1] & cs_q[1]);

    if (state_q != StIdle && cs_rise) begin
      state_d = StIdle;
      miso_d  = 1'b0;
    end else if (state_q == StIdle) begin
      if (cs_fall && armed_q) begin
        state_d   = StCmd;
        bit_cnt_d = '0;
        rx_sr_d   = '0;
        tx_sr_d   = '0;
        miso_d    = 1'b0;
      end
    end else begin
      if (sclk_rise) begin
        rx_sr_d   = rx_byte;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          unique case (state_q)
            StCmd: begin
              if (rx_byte[7]) begin
                tx_sr_d = rd_val;
                addr_d  = rx_byte[ADDR_W-1:0] + ADDR_W'(1);
                state_d = StRdata;
              end else begin
                addr_d  = rx_byte[ADDR_W-1:0];
                state_d = StWdata;
              end
            end
            StWdata: begin
              if (addr_q >= ADDR_W'(2)) begin
                regs_d[addr_q] = rx_byte;
                wr_stb_d       = 1'b1;
                wr_addr_d      = addr_q;
                wr_data_d      = rx_byte;
              end
              addr_d = addr_q + ADDR_W'(1);
            end
            StRdata: begin
              tx_sr_d = rd_val;
              addr_d  = addr_q + ADDR_W'(1);
            end
            default: ;
          endcase
        end
      end
      if (sclk_fall) begin
        miso_d  = tx_sr_q[7];
        tx_sr_d = {tx_sr_q[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q    <= 3'b000;
      cs_q      <= 3'b111;
      mosi_q    <= 2'b00;
      fill_q    <= 2'b00;
      armed_q   <= 1'b0;
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      rx_sr_q   <= '0;
      tx_sr_q   <= '0;
      addr_q    <= '0;
      miso_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      regs_q    <= '{default: '0};
    end else begin
      sclk_q    <= {sclk_q[1:0], spi_sclk};
      cs_q      <= {cs_q[1:0], spi_cs_n};
      mosi_q    <= {mosi_q[0], spi_mosi};
      fill_q    <= {fill_q[0], 1'b1};
      armed_q   <= armed_d;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_sr_q   <= rx_sr_d;
      tx_sr_q   <= tx_sr_d;
      addr_q    <= addr_d;
      miso_q    <= miso_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      regs_q    <= regs_d;
    end
  end

  assign spi_miso_oe = (state_q != StIdle);
  assign spi_miso    = miso_q & spi_miso_oe;
  assign ctrl_out    = regs_q[2];
  assign wr_stb      = wr_stb_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;

endmodule

// File: tb/tb_spi_target_regs.sv
// Directed bench for spi_target_regs: an SPI master model with scoreboard queues for
// expected read bytes and expected write strobes.
module tb_spi_target_regs;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk, cs_n, mosi;
  logic       miso, miso_oe;
  logic [7:0] ctrl_out, status_in, wr_data;
  logic       wr_stb;
  logic [2:0] wr_addr;

  int n_checks = 0;
  int n_pass   = 0;
  int n_stb    = 0;

  logic [10:0] exp_wr_q [$];
  logic [7:0]  exp_rd_q [$];

  spi_target_regs #(
    .ADDR_W   (3),
    .ID_VALUE (8'hA5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .spi_sclk    (sclk),
    .spi_cs_n    (cs_n),
    .spi_mosi    (mosi),
    .spi_miso    (miso),
    .spi_miso_oe (miso_oe),
    .ctrl_out    (ctrl_out),
    .status_in   (status_in),
    .wr_stb      (wr_stb),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every strobe must match the next expected write; a strobe with nothing pending is an error.
  always @(negedge clk) begin
    if (wr_stb !== 1'b0) begin
      n_stb++;
      if (exp_wr_q.size() == 0) begin
        check("wr_stb_unexpected", 32'(wr_stb), 32'd0);
      end else begin
        logic [10:0] e;
        e = exp_wr_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e[10:8]));
        check("wr_data", 32'(wr_data), 32'(e[7:0]));
      end
    end
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode 0: drive MOSI while SCLK is low, sample MISO just before the rising edge.
  task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = mo[i];
      clks(6);
      mi = {mi[6:0], miso};
      sclk = 1'b1;
      clks(6);
      sclk = 1'b0;
    end
  endtask

  task automatic cs_start();
    cs_n = 1'b0;
    clks(6);
  endtask

  task automatic cs_end();
    clks(6);
    cs_n = 1'b1;
    clks(8);
  endtask

  task automatic read_txn(input logic [7:0] cmd, input int n);
    logic [7:0] mi;
    cs_start();
    check("oe_active", 32'(miso_oe), 32'd1);
    xfer(cmd, 8, mi);
    check("cmd_miso_zero", 32'(mi), 32'd0);
    for (int i = 0; i < n; i++) begin
      logic [7:0] e;
      xfer(8'h00, 8, mi);
      e = exp_rd_q.pop_front();
      check("rd_byte", 32'(mi), 32'(e));
    end
    cs_end();
    check("oe_idle", 32'(miso_oe), 32'd0);
  endtask

  task automatic write_txn(input logic [7:0] cmd, input logic [31:0] d, input int n);
    logic [7:0] mi;
    cs_start();
    xfer(cmd, 8, mi);
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      b = d[31-8*i -: 8];
      xfer(b, 8, mi);
    end
    cs_end();
  endtask

  initial begin
    logic [7:0] mi;
    int         stb0;

    rst       = 1'b1;
    sclk      = 1'b0;
    cs_n      = 1'b1;
    mosi      = 1'b0;
    status_in = 8'h00;

    // Reset with random pin activity.
    for (int i = 0; i < 2; i++) begin
      sclk = 1'($urandom);
      cs_n = 1'($urandom);
      mosi = 1'($urandom);
      clks(1);
    end
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_oe", 32'(miso_oe), 32'd0);
    check("rst_ctrl", 32'(ctrl_out), 32'd0);
    sclk = 1'b0;
    cs_n = 1'b1;
    mosi = 1'b0;
    clks(1);
    rst = 1'b0;
    clks(10);
    check("rst_no_stb", 32'(n_stb), 32'd0);

    // ID read.
    exp_rd_q.push_back(8'hA5);
    read_txn(8'h80, 1);

    // Two-byte write from address 2, then read back.
    stb0 = n_stb;
    exp_wr_q.push_back({3'd2, 8'h11});
    exp_wr_q.push_back({3'd3, 8'h22});
    write_txn(8'h02, 32'h1122_0000, 2);
    check("stb_count_2", 32'(n_stb - stb0), 32'd2);
    check("ctrl_11", 32'(ctrl_out), 32'h11);
    exp_rd_q.push_back(8'h11);
    exp_rd_q.push_back(8'h22);
    read_txn(8'h82, 2);

    // Write at 7 wraps through read-only 0 and 1 into 2.
    stb0 = n_stb;
    exp_wr_q.push_back({3'd7, 8'h33});
    exp_wr_q.push_back({3'd2, 8'h66});
    write_txn(8'h07, 32'h3344_5566, 4);
    check("stb_count_wrap", 32'(n_stb - stb0), 32'd2);
    check("ctrl_66", 32'(ctrl_out), 32'h66);
    exp_rd_q.push_back(8'h33);
    exp_rd_q.push_back(8'hA5);
    read_txn(8'h87, 2);

    // Partial byte is discarded.
    stb0 = n_stb;
    cs_start();
    xfer(8'h03, 8, mi);
    xfer(8'hFF, 5, mi);
    cs_end();
    check("partial_no_stb", 32'(n_stb - stb0), 32'd0);
    exp_rd_q.push_back(8'h22);
    read_txn(8'h83, 1);

    // Status read, continuing into register 2.
    status_in = 8'h5A;
    exp_rd_q.push_back(8'h5A);
    exp_rd_q.push_back(8'h66);
    read_txn(8'h81, 2);

    // Reset mid-write with CS held low: the rest of the transfer is ignored.
    stb0 = n_stb;
    cs_start();
    xfer(8'h04, 8, mi);
    xfer(8'hFF, 3, mi);
    rst = 1'b1;
    clks(2);
    rst = 1'b0;
    clks(6);
    check("rst_mid_oe", 32'(miso_oe), 32'd0);
    check("rst_mid_ctrl", 32'(ctrl_out), 32'd0);
    xfer(8'h05, 8, mi);
    xfer(8'h77, 8, mi);
    check("rst_mid_oe_late", 32'(miso_oe), 32'd0);
    check("rst_mid_miso", 32'(mi), 32'd0);
    cs_end();
    check("rst_mid_no_stb", 32'(n_stb - stb0), 32'd0);
    exp_rd_q.push_back(8'h00);
    exp_rd_q.push_back(8'h00);
    read_txn(8'h84, 2);

    // Re-armed after CS cycled: a new write lands.
    exp_wr_q.push_back({3'd6, 8'h99});
    write_txn(8'h06, 32'h9900_0000, 1);
    exp_rd_q.push_back(8'h99);
    read_txn(8'h86, 1);

    clks(4);
    check("wr_queue_empty", 32'(exp_wr_q.size()), 32'd0);
    check("rd_queue_empty", 32'(exp_rd_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
